// File: rtl/sram_ctrl_if.sv
// Request/response bundle for the two bus masters (R = CPU, V = video) of sram_ctrl.
// The master drives strobe, address, write data and direction; the controller returns read data and ACK.
interface sram_ctrl_if;
  logic        r_stb;
  logic [19:0] r_addra;
  logic [47:0] r_dina;
  logic        r_we;
  logic [47:0] r_douta;
  logic        r_ACK;

  logic        v_stb;
  logic [19:0] v_addra;
  logic [47:0] v_dina;
  logic        v_we;
  logic [47:0] v_douta;
  logic        v_ACK;

  modport master (
    output r_stb, r_addra, r_dina, r_we,
    input  r_douta, r_ACK,
    output v_stb, v_addra, v_dina, v_we,
    input  v_douta, v_ACK
  );

  modport slave (
    input  r_stb, r_addra, r_dina, r_we,
    output r_douta, r_ACK,
    input  v_stb, v_addra, v_dina, v_we,
    output v_douta, v_ACK
  );
endinterface

// File: rtl/sram_ctrl.sv
// Time-slotted controller for one 48-bit asynchronous SRAM: scan slots and bus slots alternate every cycle.
// Scan slots always read the display word; bus slots serve one round-robin-arbitrated R/V request.
module sram_ctrl (
  input  logic        clk_50mhz,
  input  logic        rst_n,
  sram_ctrl_if.slave  bus,
  output logic [19:0] SRAM_ADDR,
  output logic        SRAM_CE,
  output logic        SRAM_OEN,
  output logic        SRAM_WEN,
  inout  wire  [47:0] SRAM_DQ,
  input  logic [19:0] vram_scan_addr,
  output logic [15:0] vram_scan_data
);

  typedef enum logic [2:0] {
    SLOT_OFF,
    SLOT_SCAN,
    SLOT_READ,
    SLOT_WRITE,
    SLOT_IDLE
  } slot_t;

  slot_t       slot, slot_nxt;
  logic        phase;
  logic        rr_v;
  logic        gnt_v;
  logic        r_elig, v_elig, pick_v, grant, sel_we;
  logic [19:0] sel_addr, addr_nxt;
  logic [47:0] wr_dat;
  logic        ce_nxt, oen_nxt, wen_nxt;
  logic        dq_oe, dq_oe_nxt;
  logic        r_ack, v_ack;
  logic [47:0] r_dout, v_dout;
  logic        bus_slot_end;

  assign bus.r_ACK   = r_ack;
  assign bus.v_ACK   = v_ack;
  assign bus.r_douta = r_dout;
  assign bus.v_douta = v_dout;

  // dq_oe and SRAM_OEN come from the same next-state decode, so the bus is never driven against the SRAM.
  assign SRAM_DQ      = dq_oe ? wr_dat : 48'bz;
  assign bus_slot_end = (slot == SLOT_READ) || (slot == SLOT_WRITE);

  always_comb begin
    r_elig   = bus.r_stb && !r_ack;
    v_elig   = bus.v_stb && !v_ack;
    pick_v   = v_elig && (!r_elig || rr_v);
    grant    = r_elig || v_elig;
    sel_we   = pick_v ? bus.v_we : bus.r_we;
    sel_addr = pick_v ? bus.v_addra : bus.r_addra;
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      slot  <= SLOT_OFF;
      phase <= 1'b0;
    end else begin
      slot  <= slot_nxt;
      phase <= (slot == SLOT_OFF) ? 1'b0 : ~phase;
    end
  end

  // SLOT_OFF only exists between reset release and the first edge, which always opens a scan slot.
  always_comb begin
    slot_nxt  = SLOT_SCAN;
    addr_nxt  = vram_scan_addr;
    ce_nxt    = 1'b0;
    oen_nxt   = 1'b0;
    wen_nxt   = 1'b1;
    dq_oe_nxt = 1'b0;
    if (slot != SLOT_OFF && !phase) begin
      addr_nxt = SRAM_ADDR;
      ce_nxt   = 1'b1;
      oen_nxt  = 1'b1;
      if (!grant) begin
        slot_nxt = SLOT_IDLE;
      end else begin
        slot_nxt  = sel_we ? SLOT_WRITE : SLOT_READ;
        addr_nxt  = sel_addr;
        ce_nxt    = 1'b0;
        oen_nxt   = sel_we;
        wen_nxt   = !sel_we;
        dq_oe_nxt = sel_we;
      end
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      SRAM_ADDR      <= 20'd0;
      SRAM_CE        <= 1'b1;
      SRAM_OEN       <= 1'b1;
      SRAM_WEN       <= 1'b1;
      dq_oe          <= 1'b0;
      rr_v           <= 1'b0;
      gnt_v          <= 1'b0;
      wr_dat         <= 48'd0;
      r_ack          <= 1'b0;
      v_ack          <= 1'b0;
      r_dout         <= 48'd0;
      v_dout         <= 48'd0;
      vram_scan_data <= 16'd0;
    end else begin
      SRAM_ADDR <= addr_nxt;
      SRAM_CE   <= ce_nxt;
      SRAM_OEN  <= oen_nxt;
      SRAM_WEN  <= wen_nxt;
      dq_oe     <= dq_oe_nxt;
      r_ack     <= bus_slot_end && !gnt_v;
      v_ack     <= bus_slot_end && gnt_v;
      if (slot == SLOT_SCAN) begin
        vram_scan_data <= SRAM_DQ[15:0];
      end
      if (slot == SLOT_READ) begin
        if (gnt_v) begin
          v_dout <= SRAM_DQ;
        end else begin
          r_dout <= SRAM_DQ;
        end
      end
      // Capture the winner at grant; the pointer then favours the other port.
      if (slot_nxt == SLOT_READ || slot_nxt == SLOT_WRITE) begin
        gnt_v  <= pick_v;
        rr_v   <= !pick_v;
        wr_dat <= pick_v ? bus.v_dina : bus.r_dina;
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: behavioural SRAM, per-port expected-result queues checked on ACK,
// continuous bus-contention checks, and directed scan / arbitration / reset scenarios.
module tb_sram_ctrl;

  logic        clk_50mhz = 1'b0;
  logic        rst_n     = 1'b0;
  wire  [47:0] sram_dq;
  logic [19:0] sram_addr;
  logic        sram_ce, sram_oen, sram_wen;
  logic [19:0] vram_scan_addr = 20'd0;
  logic [15:0] vram_scan_data;

  always #10 clk_50mhz = ~clk_50mhz;

  sram_ctrl_if bus ();

  sram_ctrl dut (
    .clk_50mhz      (clk_50mhz),
    .rst_n          (rst_n),
    .bus            (bus),
    .SRAM_ADDR      (sram_addr),
    .SRAM_CE        (sram_ce),
    .SRAM_OEN       (sram_oen),
    .SRAM_WEN       (sram_wen),
    .SRAM_DQ        (sram_dq),
    .vram_scan_addr (vram_scan_addr),
    .vram_scan_data (vram_scan_data)
  );

  // Behavioural asynchronous SRAM, aliased to 1K words.
  logic [47:0] mem [0:1023];
  assign sram_dq = (!sram_ce && !sram_oen) ? mem[sram_addr[9:0]] : 48'bz;
  always @(posedge clk_50mhz) begin
    if (!sram_ce && !sram_wen) mem[sram_addr[9:0]] <= sram_dq;
  end

  // High before the edge that opens a scan slot.
  logic scan_next;
  always @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) scan_next <= 1'b1;
    else        scan_next <= !scan_next;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic        rd;
    logic [47:0] dat;
  } exp_t;

  exp_t        r_q[$];
  exp_t        v_q[$];
  exp_t        e;
  logic [47:0] r_last = 48'd0;
  logic [47:0] v_last = 48'd0;
  logic        prev_r = 1'b0;
  logic        prev_v = 1'b0;
  int          wen_lo = 0;

  always @(negedge clk_50mhz) begin
    chk("oen_wen_both_low", 64'(!sram_oen && !sram_wen), 64'd0);
    chk("dq_driven_oen_low", 64'(!sram_oen && dut.dq_oe), 64'd0);
    if (!sram_wen) wen_lo++;
    if (bus.r_ACK) begin
      chk("r_ack_width", 64'(prev_r), 64'd0);
      if (r_q.size() == 0) begin
        chk("r_unexpected_ack", 64'd1, 64'd0);
      end else begin
        e = r_q.pop_front();
        if (e.rd) r_last = e.dat;
        chk("r_douta", 64'(bus.r_douta), 64'(r_last));
      end
    end
    if (bus.v_ACK) begin
      chk("v_ack_width", 64'(prev_v), 64'd0);
      if (v_q.size() == 0) begin
        chk("v_unexpected_ack", 64'd1, 64'd0);
      end else begin
        e = v_q.pop_front();
        if (e.rd) v_last = e.dat;
        chk("v_douta", 64'(bus.v_douta), 64'(v_last));
      end
    end
    prev_r = bus.r_ACK;
    prev_v = bus.v_ACK;
  end

  task automatic xact(input logic pv, input logic we, input logic [19:0] a, input logic [47:0] d);
    int   lat;
    int   w0;
    logic seen;
    if (pv) begin
      v_q.push_back('{rd: !we, dat: d});
      bus.v_we = we; bus.v_addra = a; bus.v_dina = d; bus.v_stb = 1'b1;
    end else begin
      r_q.push_back('{rd: !we, dat: d});
      bus.r_we = we; bus.r_addra = a; bus.r_dina = d; bus.r_stb = 1'b1;
    end
    w0   = wen_lo;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk_50mhz);
      lat++;
      if (pv ? bus.v_ACK : bus.r_ACK) seen = 1'b1;
    end
    bus.r_stb = 1'b0;
    bus.v_stb = 1'b0;
    chk(pv ? "v_ack_seen" : "r_ack_seen", 64'(seen), 64'd1);
    chk(pv ? "v_latency_le4" : "r_latency_le4", 64'(lat <= 4), 64'd1);
    chk(pv ? "v_wen_cycles" : "r_wen_cycles", 64'(wen_lo - w0), 64'(we));
  endtask

  function automatic logic [47:0] swp(input int i);
    return {16'(16'h5A00 + i), 16'h0F0F, 16'(16'h1000 + i)};
  endfunction

  task automatic align_scan();
    for (int i = 0; i < 3 && !scan_next; i++) @(negedge clk_50mhz);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ce_oen_wen"}, 64'({sram_ce, sram_oen, sram_wen}), 64'h7);
    chk({tag, "_dq_oe"}, 64'(dut.dq_oe), 64'd0);
    chk({tag, "_addr"}, 64'(sram_addr), 64'd0);
    chk({tag, "_acks"}, 64'({bus.r_ACK, bus.v_ACK}), 64'd0);
    chk({tag, "_r_douta"}, 64'(bus.r_douta), 64'd0);
    chk({tag, "_v_douta"}, 64'(bus.v_douta), 64'd0);
    chk({tag, "_scan"}, 64'(vram_scan_data), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int   rc, vc, last_p, first_p, ack_cnt;
    int   r_gap, v_gap, r_gap_max, v_gap_max;
    logic seen;

    bus.r_stb = 1'b0; bus.r_we = 1'b0; bus.r_addra = 20'd0; bus.r_dina = 48'd0;
    bus.v_stb = 1'b0; bus.v_we = 1'b0; bus.v_addra = 20'd0; bus.v_dina = 48'd0;

    // Reset values, then the first edge after release must open a scan slot.
    #35;
    check_reset_vals("reset");
    vram_scan_addr = 20'h00123;
    @(negedge clk_50mhz);
    rst_n = 1'b1;
    @(negedge clk_50mhz);
    chk("first_scan_ctrl", 64'({sram_ce, sram_oen, sram_wen}), 64'h1);
    chk("first_scan_addr", 64'(sram_addr), 64'h00123);

    // Write then read back on R; then V write/read to a different address.
    xact(1'b0, 1'b1, 20'h00010, 48'h123456789ABC);
    xact(1'b0, 1'b0, 20'h00010, 48'h123456789ABC);
    xact(1'b1, 1'b1, 20'h00020, 48'hFEDCBA987654);
    xact(1'b1, 1'b0, 20'h00020, 48'hFEDCBA987654);
    xact(1'b0, 1'b0, 20'h00020, 48'hFEDCBA987654);
    xact(1'b1, 1'b0, 20'h00010, 48'h123456789ABC);

    // Scan port picks up a word and refreshes after it is overwritten.
    xact(1'b0, 1'b1, 20'h00200, 48'h00000000BEEF);
    align_scan();
    vram_scan_addr = 20'h00200;
    repeat (2) @(negedge clk_50mhz);
    chk("scan_beef", 64'(vram_scan_data), 64'hBEEF);
    repeat (2) @(negedge clk_50mhz);
    chk("scan_beef_hold", 64'(vram_scan_data), 64'hBEEF);
    xact(1'b0, 1'b1, 20'h00200, 48'h00000000CAFE);
    repeat (2) @(negedge clk_50mhz);
    chk("scan_refresh", 64'(vram_scan_data), 64'hCAFE);

    // V reads while the scan address sweeps 0..15, one word per 2 cycles.
    for (int i = 0; i < 16; i++) xact(1'b1, 1'b1, 20'(i), swp(i));
    fork
      begin
        align_scan();
        for (int a = 0; a < 16; a++) begin
          vram_scan_addr = 20'(a);
          repeat (2) @(negedge clk_50mhz);
          chk("scan_sweep", 64'(vram_scan_data), 64'(swp(a) & 48'hFFFF));
        end
      end
      begin
        for (int a = 15; a >= 0; a--) xact(1'b1, 1'b0, 20'(a), swp(a));
      end
    join
    vram_scan_addr = 20'h00200;

    // Reset in the middle of a granted write: abort with no ACK.
    bus.r_we = 1'b1; bus.r_addra = 20'h00030; bus.r_dina = 48'hDEADDEADDEAD; bus.r_stb = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk_50mhz);
      if (!sram_wen) seen = 1'b1;
    end
    chk("abort_write_started", 64'(seen), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("abort");
    bus.r_stb = 1'b0;
    r_last    = 48'd0;
    v_last    = 48'd0;
    ack_cnt   = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_50mhz);
      if (i == 3) rst_n = 1'b1;
      if (bus.r_ACK || bus.v_ACK) ack_cnt++;
    end
    chk("abort_no_ack", 64'(ack_cnt), 64'd0);
    chk("abort_scan_after", 64'(vram_scan_data), 64'hCAFE);

    // Both strobes held: grants must alternate starting with R.
    for (int i = 0; i < 4; i++) begin
      r_q.push_back('{rd: 1'b1, dat: 48'h123456789ABC});
      v_q.push_back('{rd: 1'b1, dat: 48'h00000000CAFE});
    end
    bus.r_we = 1'b0; bus.r_addra = 20'h00010;
    bus.v_we = 1'b0; bus.v_addra = 20'h00200;
    bus.r_stb = 1'b1; bus.v_stb = 1'b1;
    rc = 0; vc = 0; last_p = -1; first_p = -1;
    r_gap = 0; v_gap = 0; r_gap_max = 0; v_gap_max = 0;
    for (int i = 0; i < 60 && (rc < 4 || vc < 4); i++) begin
      @(negedge clk_50mhz);
      r_gap++; v_gap++;
      if (bus.r_ACK && bus.v_ACK) chk("both_ack", 64'd1, 64'd0);
      if (bus.r_ACK) begin
        if (first_p < 0) first_p = 0;
        if (last_p >= 0) chk("alternate_r", 64'(last_p), 64'd1);
        last_p = 0; rc++;
        if (r_gap > r_gap_max) r_gap_max = r_gap;
        r_gap = 0;
        if (rc == 4) bus.r_stb = 1'b0;
      end
      if (bus.v_ACK) begin
        if (first_p < 0) first_p = 1;
        if (last_p >= 0) chk("alternate_v", 64'(last_p), 64'd0);
        last_p = 1; vc++;
        if (v_gap > v_gap_max) v_gap_max = v_gap;
        v_gap = 0;
        if (vc == 4) bus.v_stb = 1'b0;
      end
    end
    bus.r_stb = 1'b0;
    bus.v_stb = 1'b0;
    chk("contention_first_r", 64'(first_p), 64'd0);
    chk("contention_r_count", 64'(rc), 64'd4);
    chk("contention_v_count", 64'(vc), 64'd4);
    chk("contention_r_lat_le6", 64'(r_gap_max <= 6), 64'd1);
    chk("contention_v_lat_le6", 64'(v_gap_max <= 6), 64'd1);
    repeat (4) @(negedge clk_50mhz);
    chk("queues_drained", 64'(r_q.size() + v_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
